md_ctrl: RTL
============

Name: md_ctrl

Overview:
- Iterative multiply/divide sequencer beside the Execute-stage ALU; owns the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU from E stage and runs a 32-iteration shift-add or restoring-divide loop.
- Raises mdBusy so the hazard unit stalls dependent instructions.
- Also handles the single-cycle MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- ITER, 32, loop iterations; must equal WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- mdValidE  in  1  E-stage instruction is valid and carries mdOpE
- mdOpE  in  3  op: 000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
- SrcA  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
- SrcB  in  32  rt operand (divisor / multiplier)
- flushE  in  1  cancel any in-flight or requested operation
- hiOut  out  32  HI register
- loOut  out  32  LO register
- mdBusy  out  1  registered; high in RUN and FIX
- mdDone  out  1  registered one-cycle pulse when HI/LO were just updated by MULT/DIV

Behaviour:
- Reset, asynchronous on resetn=0, effective at any time including mid-operation:
  - state=IDLE, hiOut=0, loOut=0, mdBusy=0, mdDone=0, counter=0.
- States: IDLE, RUN, FIX.
- IDLE:
  - If mdValidE=1, flushE=0 and op is MULT/MULTU/DIV/DIVU:
    - latch |SrcA|, |SrcB| (signed ops) or raw values (unsigned ops);
    - latch the result-sign and remainder-sign flags;
    - clear the 64-bit accumulator; counter=0; go to RUN.
  - If mdValidE=1, flushE=0 and op is MTHI/MTLO: hiOut/loOut = SrcA at this edge; stay in IDLE; mdDone stays 0.
  - NONE, or flushE=1: no change.
- RUN:
  - One iteration per cycle; counter increments; after the 32nd iteration (counter==31) go to FIX.
  - mdValidE is ignored while busy; the hazard unit holds the pipeline.
- Multiply: unsigned shift-add; multiplier LSB conditionally adds the multiplicand into the upper half, then shift right 1.
- Divide: restoring; shift {rem,quot} left 1, trial-subtract the divisor, set quotient bit when there is no borrow.
- FIX:
  - Multiply: negate the 64-bit product if the sign flag is set.
  - Divide: negate the quotient if the signs differ; negate the remainder if the dividend was negative.
  - Write HI/LO at the FIX edge (mult: HI=upper, LO=lower; div: HI=remainder, LO=quotient).
  - Assert mdDone for the following cycle; return to IDLE.
- Latency:
  - Accept edge = T0; mdBusy=1 during cycles T1..T33.
  - HI/LO are valid and mdDone=1 in cycle T34; a new op is accepted at the T34 edge.
- flushE=1 in RUN or FIX: return to IDLE at that edge; HI/LO unchanged; no mdDone.
- Divide by zero (DIV and DIVU): runs the full latency; LO=32'hFFFFFFFF, HI=SrcA.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (the natural result of the abs-value algorithm).
- Arithmetic width rules:
  - All internal arithmetic is unsigned, 33-bit for the trial subtract and carry-out.
  - Abs of 0x80000000 is 0x80000000 treated as unsigned.

Decomposition:
- Shared defines header gets:
  - MD_OP_* encodings (3-bit);
  - MD_OP_LENGTH;
  - state encodings MD_IDLE/MD_RUN/MD_FIX.
- WORD_WIDTH and ZEROWORD are reused from the existing header.
- Single sub-module md_iter_step: combinational one-iteration datapath.
  - Inputs: op class, accumulator, operand register.
  - Output: next accumulator.
- md_ctrl holds the FSM, counter, sign fix-up and HI/LO registers.

Test Plan:
- MULTU SrcA=FFFFFFFF SrcB=FFFFFFFF -> mdBusy high 33 cycles, then HI=FFFFFFFE LO=00000001, mdDone single pulse.
- MULT SrcA=FFFFFFFD(-3) SrcB=00000007 -> HI=FFFFFFFF LO=FFFFFFEB; then DIV SrcA=FFFFFFF9(-7) SrcB=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF.
- DIVU SrcA=0000002A SrcB=0 -> LO=FFFFFFFF HI=0000002A after 33 busy cycles; DIV 80000000/FFFFFFFF -> LO=80000000 HI=0.
- MULT in flight with HI=11111111, LO=22222222; flushE=1 at RUN cycle 10 -> IDLE next cycle, mdBusy=0, HI/LO unchanged, no mdDone.
- MTHI SrcA=DEADBEEF then MTLO SrcA=CAFEF00D in consecutive IDLE cycles -> HI/LO updated at each edge, mdBusy never asserted; mdValidE+MULT with flushE=1 -> not accepted.
- resetn pulsed low mid-RUN (asynchronous, between edges) -> immediate IDLE, HI=LO=0, mdBusy=0; next MULTU 3*5 -> LO=0000000F HI=0.

Source files
------------

// File: rtl/md_ctrl_pkg.sv
// md_ctrl_pkg: shared op/state encodings and word constants for the multiply/divide sequencer.
package md_ctrl_pkg;
  localparam int WORD_WIDTH = 32;
  localparam logic [WORD_WIDTH-1:0] ZEROWORD = '0;
  localparam int MD_OP_LENGTH = 3;
  localparam logic [MD_OP_LENGTH-1:0] MD_OP_NONE  = 3'b000;
  localparam logic [MD_OP_LENGTH-1:0] MD_OP_MULT  = 3'b001;
  localparam logic [MD_OP_LENGTH-1:0] MD_OP_MULTU = 3'b010;
  localparam logic [MD_OP_LENGTH-1:0] MD_OP_DIV   = 3'b011;
  localparam logic [MD_OP_LENGTH-1:0] MD_OP_DIVU  = 3'b100;
  localparam logic [MD_OP_LENGTH-1:0] MD_OP_MTHI  = 3'b101;
  localparam logic [MD_OP_LENGTH-1:0] MD_OP_MTLO  = 3'b110;
  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX} md_state_e;
endpackage

// File: rtl/md_iter_step.sv
// md_iter_step: one unsigned shift-add multiply or restoring-divide iteration on the 64-bit accumulator.
module md_iter_step
  import md_ctrl_pkg::*;
(
  input  logic                      is_div,
  input  logic [2*WORD_WIDTH-1:0]   acc,
  input  logic [WORD_WIDTH-1:0]     opnd,
  output logic [2*WORD_WIDTH-1:0]   acc_nxt
);
  localparam int W = WORD_WIDTH;
  logic [W:0]   sum;
  logic [W-1:0] rem_sub;
  logic         no_borrow;
  // divide: acc[2W-1:W-1] is the shifted remainder including its carried-out top bit
  always_comb begin
    sum = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
    no_borrow = acc[2*W-1:W-1] >= {1'b0, opnd};
    rem_sub = acc[2*W-2:W-1] - opnd;
    acc_nxt = is_div ? (no_borrow ? {rem_sub, acc[W-2:0], 1'b1} : {acc[2*W-2:0], 1'b0})
                     : (acc[0] ? {sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]});
  end
endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, plus single-cycle MTHI/MTLO.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    mdValidE,
  input  logic [MD_OP_LENGTH-1:0] mdOpE,
  input  logic [WIDTH-1:0]        SrcA,
  input  logic [WIDTH-1:0]        SrcB,
  input  logic                    flushE,
  output logic [WIDTH-1:0]        hiOut,
  output logic [WIDTH-1:0]        loOut,
  output logic                    mdBusy,
  output logic                    mdDone
);
  localparam int CW = $clog2(ITER);
  md_state_e state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_step, prod;
  logic [WIDTH-1:0] opnd, abs_a, abs_b, quot, rem;
  logic is_div, res_neg, rem_neg, valid, start, sgn, div_op;
  assign valid = mdValidE && !flushE && state == MD_IDLE;
  assign start = valid && mdOpE inside {[MD_OP_MULT:MD_OP_DIVU]};
  assign div_op = mdOpE == MD_OP_DIV || mdOpE == MD_OP_DIVU;
  assign sgn = mdOpE == MD_OP_MULT || mdOpE == MD_OP_DIV;
  assign abs_a = sgn && SrcA[WIDTH-1] ? -SrcA : SrcA;
  assign abs_b = sgn && SrcB[WIDTH-1] ? -SrcB : SrcB;
  assign prod = res_neg ? -acc : acc;
  assign quot = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  md_iter_step u_step (.is_div(is_div), .acc(acc), .opnd(opnd), .acc_nxt(acc_step));
  always_comb
    state_nxt = state == MD_IDLE ? (start ? MD_RUN : MD_IDLE)
              : state == MD_RUN  ? (flushE ? MD_IDLE : cnt == CW'(ITER-1) ? MD_FIX : MD_RUN)
              : MD_IDLE;
  // divide-by-zero keeps an all-ones quotient regardless of operand signs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= MD_IDLE;
      cnt <= '0;
      acc <= '0;
      opnd <= ZEROWORD;
      is_div <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      hiOut <= ZEROWORD;
      loOut <= ZEROWORD;
      mdBusy <= 1'b0;
      mdDone <= 1'b0;
    end else begin
      state <= state_nxt;
      mdBusy <= state_nxt != MD_IDLE;
      mdDone <= state == MD_FIX && !flushE;
      cnt <= state == MD_RUN ? cnt + 1'b1 : '0;
      if (start) begin
        is_div <= div_op;
        res_neg <= sgn && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]) && !(div_op && SrcB == ZEROWORD);
        rem_neg <= sgn && div_op && SrcA[WIDTH-1];
        opnd <= div_op ? abs_b : abs_a;
        acc <= {ZEROWORD, div_op ? abs_a : abs_b};
      end else if (state == MD_RUN) acc <= acc_step;
      if (valid && mdOpE == MD_OP_MTHI) hiOut <= SrcA;
      if (valid && mdOpE == MD_OP_MTLO) loOut <= SrcA;
      if (state == MD_FIX && !flushE) begin
        hiOut <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
        loOut <= is_div ? quot : prod[WIDTH-1:0];
      end
    end
  end
endmodule
